// File: rtl/blake2b_round_ctrl.sv
// blake2b_round_ctrl: BLAKE2b compression round sequencer feeding four parallel G units.
// Define BLAKE2B_REDUCED_ROUNDS_EN for a non-standard 2-round build (simulation speed-up only).
module blake2b_round_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [511:0] h_i,
  input  logic [127:0] t_i,
  input  logic         last_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [511:0] h_o,
  output logic [11:0]  g_index_o,
  output logic [3:0]   g_round_o,
  output logic [255:0] g_a_o,
  output logic [255:0] g_b_o,
  output logic [255:0] g_c_o,
  output logic [255:0] g_d_o,
  input  logic [255:0] g_a_i,
  input  logic [255:0] g_b_i,
  input  logic [255:0] g_c_i,
  input  logic [255:0] g_d_i
);
`ifdef BLAKE2B_REDUCED_ROUNDS_EN
  localparam logic [3:0] LAST_R = 4'd1;
`else
  localparam logic [3:0] LAST_R = 4'd11;
`endif
  localparam logic [511:0] IV = {64'h5BE0CD19137E2179, 64'h1F83D9ABFB41BD6B,
                                 64'h9B05688C2B3E6C1F, 64'h510E527FADE682D1,
                                 64'hA54FF53A5F1D36F1, 64'h3C6EF372FE94F82B,
                                 64'hBB67AE8584CAA73B, 64'h6A09E667F3BCC908};
  typedef enum logic [2:0] {IDLE, INIT, ISSUE, CAPTURE, FINAL} state_e;
  state_e            state_q, state_d;
  logic [15:0][63:0] v_q, v_d;
  logic [511:0]      h_q, h_d, ho_q, ho_d;
  logic [127:0]      t_q, t_d;
  logic              f_q, f_d, s_q, s_d, done_q, done_d;
  logic [3:0]        r_q, r_d;
  logic [3:0]        pb [4];
  logic [3:0]        pc [4];
  logic [3:0]        pd [4];

  for (genvar k = 0; k < 4; k++) begin : g_unit
    // the diagonal step rotates the b/c/d rows by 1/2/3 lanes
    assign pb[k] = {2'b01, 2'(k) + (s_q ? 2'd1 : 2'd0)};
    assign pc[k] = {2'b10, 2'(k) + (s_q ? 2'd2 : 2'd0)};
    assign pd[k] = {2'b11, 2'(k) + (s_q ? 2'd3 : 2'd0)};
    assign g_a_o[64*k +: 64] = v_q[k];
    assign g_b_o[64*k +: 64] = v_q[pb[k]];
    assign g_c_o[64*k +: 64] = v_q[pc[k]];
    assign g_d_o[64*k +: 64] = v_q[pd[k]];
    assign g_index_o[3*k +: 3] = (state_q == IDLE) ? 3'd0 : {s_q, 2'(k)};
  end

  assign g_round_o = (r_q >= 4'd10) ? r_q - 4'd10 : r_q;
  assign busy_o    = state_q != IDLE;
  assign done_o    = done_q;
  assign h_o       = ho_q;

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    h_d     = h_q;
    t_d     = t_q;
    f_d     = f_q;
    r_d     = r_q;
    s_d     = s_q;
    ho_d    = ho_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        h_d     = h_i;
        t_d     = t_i;
        f_d     = last_i;
        state_d = INIT;
      end
      INIT: begin
        v_d     = {IV ^ {64'd0, {64{f_q}}, t_q, 256'd0}, h_q};
        r_d     = 4'd0;
        s_d     = 1'b0;
        state_d = ISSUE;
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        for (int k = 0; k < 4; k++) begin
          v_d[k]     = g_a_i[64*k +: 64];
          v_d[pb[k]] = g_b_i[64*k +: 64];
          v_d[pc[k]] = g_c_i[64*k +: 64];
          v_d[pd[k]] = g_d_i[64*k +: 64];
        end
        s_d     = ~s_q;
        r_d     = (s_q && r_q != LAST_R) ? r_q + 4'd1 : r_q;
        state_d = (s_q && r_q == LAST_R) ? FINAL : ISSUE;
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) ho_d[64*i +: 64] = h_q[64*i +: 64] ^ v_q[i] ^ v_q[i+8];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      v_q     <= '0;
      h_q     <= '0;
      t_q     <= '0;
      f_q     <= 1'b0;
      r_q     <= 4'd0;
      s_q     <= 1'b0;
      ho_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      h_q     <= h_d;
      t_q     <= t_d;
      f_q     <= f_d;
      r_q     <= r_d;
      s_q     <= s_d;
      ho_q    <= ho_d;
      done_q  <= done_d;
    end
  end
endmodule
